lsu_mem_master: RTL and testbench

//  Load/store initiator between the core and the word-addressed data memory
//  (32-bit words, WE-edge write, combinational read). Accepts one byte, halfword
//  or word request from the core, performs read-modify-write for sub-word stores,
//  and issues glitch-free single WE pulses. It also extracts and sign/zero-extends

---
 rtl/lsu_mem_master.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed, combinational-read data memory.
// Sub-word stores use read-modify-write; mem_we is a registered single-cycle pulse.
module lsu_mem_master #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  // state | meaning
  // IDLE  | waiting for a request (req_ready high from the second cycle on)
  // READ  | mem_a driven, old word / load data sampled from mem_rd
  // SETUP | mem_a/mem_wd settled ahead of the write strobe
  // WRITE | mem_we high for exactly this cycle
  // HOLD  | address/data held after the falling strobe
  // RESP  | rsp_valid strobe
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  logic [2:0]  state;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [1:0]  lane_r;
  logic [15:0] wdata_r;

  logic        req_err;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      3'b001, 3'b101:         if (req_addr[0]) req_err = 1'b1;
      3'b010:                 if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default:                ;
    endcase
    if (req_we && req_funct3[2]) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_LIMIT) req_err = 1'b1;
  end

  // Little-endian lane select: shifting by lane*8 puts the addressed byte/half at bit 0.
  always_comb begin
    shifted = mem_rd >> {lane_r, 3'b000};
    case (f3_r)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rd;
    endcase
  end

  always_comb begin
    merge_data = mem_rd;
    if (f3_r[1:0] == 2'b00)
      merge_data[{lane_r, 3'b000} +: 8] = wdata_r[7:0];
    else
      merge_data[{lane_r[1], 4'b0000} +: 16] = wdata_r;
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      we_r      <= 1'b0;
      f3_r      <= 3'b000;
      lane_r    <= 2'b00;
      wdata_r   <= 16'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_a     <= 32'h0;
      mem_wd    <= 32'h0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            we_r      <= req_we;
            f3_r      <= req_funct3;
            lane_r    <= req_addr[1:0];
            wdata_r   <= req_wdata[15:0];
            if (req_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              mem_a <= {2'b00, req_addr[31:2]};
              if (req_we && req_funct3[1:0] == 2'b10) begin
                mem_wd <= req_wdata;
                state  <= SETUP;
              end else begin
                state <= READ;
              end
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        READ: begin
          if (!we_r) begin
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else begin
            mem_wd <= merge_data;
            state  <= SETUP;
          end
        end
        SETUP: begin
          mem_we <= 1'b1;
          state  <= WRITE;
        end
        WRITE: state <= HOLD;
        HOLD: begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural data memory,
// an expected-response queue and a latency/ordering monitor.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  lsu_mem_master #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          acc_log[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          we_edges = 0;
  logic [31:0] last_wa;
  logic [31:0] last_wd;
  logic [31:0] tb_mem [0:255];
  exp_t        mon_e;
  int          mon_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rd = (mem_a < 32'd256) ? tb_mem[mem_a[7:0]] : 32'h0;

  always @(posedge mem_we) begin
    we_edges++;
    last_wa = mem_a;
    last_wd = mem_wd;
    if (mem_a < 32'd256) tb_mem[mem_a[7:0]] = mem_wd;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk)
    if (rst_n && req_valid && req_ready) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end

  always @(negedge clk)
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("spurious_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        chk("rsp_latency", 64'(cyc - mon_a), 64'(mon_e.lat));
      end
    end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic err,
                        input logic [31:0] rdata, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.err = err; e.rdata = rdata; e.lat = lat;
    exp_q.push_back(e);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("rsp_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int n0;
    logic [31:0] exp_w8;
    exp_t e;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    tb_mem[5] = 32'h11223344;

    #12;
    chk("reset_ctrl", {60'h0, req_ready, rsp_valid, rsp_err, mem_we}, 64'h0);
    chk("reset_rdata_a", {rsp_rdata, mem_a}, 64'h0);
    chk("reset_wd", 64'(mem_wd), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // 1: SW
    base = we_edges;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 4);
    wait_rsp();
    chk("sw_we_edges", 64'(we_edges - base), 64'd1);
    chk("sw_mem_a", 64'(last_wa), 64'd4);
    chk("sw_mem_wd", 64'(last_wd), 64'hDEADBEEF);
    chk("sw_mem4", 64'(tb_mem[4]), 64'hDEADBEEF);

    // 2: sub-word loads
    base = we_edges;
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 2); wait_rsp();
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000DE, 2); wait_rsp();
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 2); wait_rsp();
    do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000BEEF, 2); wait_rsp();
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFFBE, 2); wait_rsp();
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2); wait_rsp();
    chk("load_we_edges", 64'(we_edges - base), 64'd0);

    // 3: read-modify-write
    base = we_edges;
    do_req(1'b1, 3'b000, 32'h15, 32'hFFFFFFAA, 1'b0, 32'h0, 5); wait_rsp();
    chk("sb_mem5", 64'(tb_mem[5]), 64'h1122AA44);
    do_req(1'b1, 3'b001, 32'h16, 32'h12345566, 1'b0, 32'h0, 5); wait_rsp();
    chk("sh_mem5", 64'(tb_mem[5]), 64'h5566AA44);
    chk("rmw_we_edges", 64'(we_edges - base), 64'd2);
    do_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'h5566AA44, 2); wait_rsp();

    // 4: rejected requests
    base = we_edges;
    do_req(1'b0, 3'b010, 32'h06,  32'h0, 1'b1, 32'h0, 1); wait_rsp();
    do_req(1'b1, 3'b001, 32'h03,  32'h0000FFFF, 1'b1, 32'h0, 1); wait_rsp();
    do_req(1'b0, 3'b011, 32'h10,  32'h0, 1'b1, 32'h0, 1); wait_rsp();
    do_req(1'b1, 3'b100, 32'h10,  32'h000000FF, 1'b1, 32'h0, 1); wait_rsp();
    do_req(1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, 1); wait_rsp();
    chk("err_we_edges", 64'(we_edges - base), 64'd0);
    chk("err_mem4_intact", 64'(tb_mem[4]), 64'hDEADBEEF);

    // 5: reset during WRITE
    do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 4);
    n = 0;
    while (mem_we !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("write_seen", 64'(mem_we), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_hold_ready", {62'h0, req_ready, rsp_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rerelease", 64'(req_ready), 64'd1);
    exp_w8 = tb_mem[8];
    chk("w8_old_or_new", 64'(exp_w8 == 32'h0 || exp_w8 == 32'hCAFEF00D), 64'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, exp_w8, 2); wait_rsp();

    // 6: req_valid held across two loads
    n0 = acc_log.size();
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'h0;
    e.err = 1'b0; e.rdata = 32'h00000044; e.lat = 2;
    exp_q.push_back(e);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    req_funct3 = 3'b101; req_addr = 32'h16;
    e.err = 1'b0; e.rdata = 32'h00005566; e.lat = 2;
    exp_q.push_back(e);
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("b2b_accept_timeout", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp();
    chk("b2b_accepts", 64'(acc_log.size() - n0), 64'd2);
    if (acc_log.size() - n0 == 2)
      chk("b2b_gap", 64'(acc_log[n0 + 1] - acc_log[n0]), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
